// File: rtl/conv_window_reader.sv
`default_nettype none
// ============================================================================
// conv_window_reader: walks every KxK valid-convolution window of the image
// in raster order, fetching one pixel per handshake from four byte-lane RAMs.
// Revision: 1.0
// ============================================================================
module conv_window_reader #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int K      = 3,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [7:0]        rd_q0,
   input  logic [7:0]        rd_q1,
   input  logic [7:0]        rd_q2,
   input  logic [7:0]        rd_q3,
   output logic [7:0]        pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_first,
   output logic              pix_last,
   output logic [4:0]        win_row,
   output logic [4:0]        win_col
);

   localparam int P_RAW = $clog2(IMG_W * IMG_H);
   localparam int P_W   = (P_RAW < 10) ? 10 : P_RAW;
   localparam int KW    = (K > 1) ? $clog2(K) : 1;

   localparam logic [KW-1:0] C_K_MAX   = KW'(K - 1);
   localparam logic [4:0]    C_COL_MAX = 5'(IMG_W - K);
   localparam logic [4:0]    C_ROW_MAX = 5'(IMG_H - K);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_WAIT  = 3'd2,
      S_VALID = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [KW-1:0]     kc_q, kc_d, kr_q, kr_d;
   logic [4:0]        wc_q, wc_d, wr_q, wr_d;
   logic [1:0]        lane_q, lane_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        data_q, data_d;
   logic              first_q, first_d, last_q, last_d;
   logic [4:0]        row_q, row_d, col_q, col_d;

   logic [KW-1:0]     kc_nx, kr_nx;
   logic [4:0]        wc_nx, wr_nx;
   logic              end_of_pass;
   logic [P_W-1:0]    p_nx;
   logic [7:0]        lane_data;

   // Counters after one step of the kc -> kr -> win_col -> win_row odometer.
   always_comb begin
      kc_nx = kc_q;
      kr_nx = kr_q;
      wc_nx = wc_q;
      wr_nx = wr_q;
      if (kc_q != C_K_MAX) begin
         kc_nx = kc_q + 1'b1;
      end else begin
         kc_nx = '0;
         if (kr_q != C_K_MAX) begin
            kr_nx = kr_q + 1'b1;
         end else begin
            kr_nx = '0;
            if (wc_q != C_COL_MAX) begin
               wc_nx = wc_q + 1'b1;
            end else begin
               wc_nx = '0;
               wr_nx = wr_q + 1'b1;
            end
         end
      end
   end

   assign end_of_pass = (kc_q == C_K_MAX) && (kr_q == C_K_MAX) &&
                        (wc_q == C_COL_MAX) && (wr_q == C_ROW_MAX);

   assign p_nx = (P_W'(wr_nx) + P_W'(kr_nx)) * P_W'(IMG_W) + P_W'(wc_nx) + P_W'(kc_nx);

   always_comb begin
      case (lane_q)
         2'd0:    lane_data = rd_q0;
         2'd1:    lane_data = rd_q1;
         2'd2:    lane_data = rd_q2;
         default: lane_data = rd_q3;
      endcase
   end

   always_comb begin
      state_d = state_q;
      kc_d    = kc_q;
      kr_d    = kr_q;
      wc_d    = wc_q;
      wr_d    = wr_q;
      lane_d  = lane_q;
      addr_d  = addr_q;
      data_d  = data_q;
      first_d = first_q;
      last_d  = last_q;
      row_d   = row_q;
      col_d   = col_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ADDR;
               kc_d    = '0;
               kr_d    = '0;
               wc_d    = '0;
               wr_d    = '0;
               addr_d  = '0;
               lane_d  = '0;
            end
         end
         S_ADDR: state_d = S_WAIT;
         S_WAIT: begin
            state_d = S_VALID;
            data_d  = lane_data;
            first_d = (kr_q == '0) && (kc_q == '0);
            last_d  = (kr_q == C_K_MAX) && (kc_q == C_K_MAX);
            row_d   = wr_q;
            col_d   = wc_q;
         end
         S_VALID: begin
            if (pix_ready) begin
               if (end_of_pass) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ADDR;
                  kc_d    = kc_nx;
                  kr_d    = kr_nx;
                  wc_d    = wc_nx;
                  wr_d    = wr_nx;
                  addr_d  = ADDR_W'(p_nx[P_W-1:2]);
                  lane_d  = p_nx[1:0];
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         kc_q    <= '0;
         kr_q    <= '0;
         wc_q    <= '0;
         wr_q    <= '0;
         lane_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         kc_q    <= kc_d;
         kr_q    <= kr_d;
         wc_q    <= wc_d;
         wr_q    <= wr_d;
         lane_q  <= lane_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         first_q <= first_d;
         last_q  <= last_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign pix_valid = (state_q == S_VALID);
   assign ram_addr  = addr_q;
   assign pix_data  = data_q;
   assign pix_first = first_q;
   assign pix_last  = last_q;
   assign win_row   = row_q;
   assign win_col   = col_q;

endmodule

`default_nettype wire

// File: doc/conv_window_reader.md
Name: conv_window_reader

Overview:
- Downstream consumer of the image-load stage.
- After the loader has filled the four byte-lane image RAMs, this block walks every KxK valid-convolution window of the IMG_H x IMG_W image in raster order.
- It drives the shared 14-bit image RAM read address, selects the correct byte lane, and streams one pixel per valid/ready handshake to the convolution MAC.
- Window-position tags and first/last markers travel with each pixel.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- K, 3, square kernel size
- ADDR_W, 14, image RAM word-address width

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a full pass; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE completes
- done  out  1  one-cycle pulse after the final pixel handshake
- ram_addr  out  ADDR_W  registered word address to all four image RAMs
- rd_q0, rd_q1, rd_q2, rd_q3  in  8 each  q outputs of image RAMs lane 0..3
- pix_data  out  8  pixel value
- pix_valid  out  1  pix_data and tags valid
- pix_ready  in  1  MAC accepts the pixel
- pix_first  out  1  pixel is kr=0, kc=0 of its window
- pix_last  out  1  pixel is kr=K-1, kc=K-1 of its window
- win_row  out  5  output row of the current window
- win_col  out  5  output column of the current window

Behaviour:
- Storage map:
  - Pixel index p = r*IMG_W + c.
  - Word address = p>>2.
  - Lane = p[1:0]; lane 0 holds the lowest pixel of the word.
  - Compute p at ≥10 bits; zero-extend the word address to ADDR_W.
- Traversal order:
  - Windows: win_row 0..IMG_H-K (outer), win_col 0..IMG_W-K (inner).
  - Within a window: kr 0..K-1 (outer), kc 0..K-1 (inner).
  - Pixel address uses r = win_row+kr, c = win_col+kc.
  - Defaults give 26*26*9 = 6084 pixels per pass.
- RAM timing: the address is sampled at a clock edge and q is valid in the following cycle.
- FSM states: IDLE, ADDR, WAIT, VALID, DONE.
  - IDLE: start=1 → ADDR. Counters are zeroed, and ram_addr and lane are registered for pixel (0,0,0,0).
  - ADDR: RAM samples ram_addr at this edge → WAIT.
  - WAIT: pix_data <= rd_q[lane] → VALID. Tags are registered in the same edge.
  - VALID: pix_valid=1. Behaviour depends on pix_ready:
    - pix_ready=0: stay in VALID. pix_data, tags and ram_addr are held stable.
    - pix_ready=1 on any pixel except the last of the pass: advance kc→kr→win_col→win_row with wrap, register the next ram_addr/lane, → ADDR.
    - pix_ready=1 on the last pixel of the last window: → DONE.
  - DONE: done=1 and pix_valid=0 for one cycle → IDLE. busy drops in IDLE.
- Latency and throughput:
  - start sampled high → pix_valid high 3 cycles later.
  - Steady state is one pixel per 3 cycles with pix_ready held high.
- pix_valid, once asserted, is never withdrawn before the handshake (except by reset).
- start is ignored in ADDR, WAIT, VALID and DONE.
- Reset (asserted low, asynchronous, any state):
  - FSM → IDLE.
  - All counters 0.
  - Outputs: ram_addr=0, pix_data=0, pix_valid=0, pix_first=0, pix_last=0, win_row=0, win_col=0, busy=0, done=0.
  - A pass interrupted by reset is abandoned, not resumed.
- Counter wrap:
  - kc wraps at K-1 and increments kr.
  - kr wraps at K-1 and increments win_col.
  - win_col wraps at IMG_W-K and increments win_row.
  - win_row at IMG_H-K together with all other counters at maximum marks end of pass.

Test Plan:
- Reset check: assert reset low mid-pass while pix_valid=1 → pix_valid, busy and ram_addr go to 0 immediately, with no clock required. After release, state is IDLE and the first post-reset start behaves normally.
- First window: preload pixel p = p mod 256, ready always high, pulse start.
  - pix_valid rises 3 cycles after start.
  - Pixels are 0,1,2,28,29,30,56,57,58.
  - pix_first is set on 0 only and pix_last on 58 only.
  - win_row=0 and win_col=0.
  - ram_addr sequence is 0,0,0,7,7,7,14,14,14.
- Lane select, second window (win_col=1):
  - Pixels are 1,2,3,29,30,31,57,58,59.
  - The first pixel comes from ram_addr 0, lane 1; the pixel 3 fetch uses lane 3.
- Backpressure: hold pix_ready low 5 cycles on the 4th pixel (value 28) → pix_data=28 and ram_addr stable throughout. On release the next pixel is 29, with no loss or duplicate.
- Last window and completion:
  - Window win_row=25, win_col=25 yields 213,214,215,241,242,243,13,14,15 (p 725..783 mod 256).
  - Exactly 6084 handshakes occur in total.
  - done pulses one cycle after the last handshake, then busy=0.
- start while busy: pulse start during VALID of window 3 → no restart. Sequence and handshake count are unchanged, and there is exactly one done pulse.
